// File: rtl/difftest_commit_tracker_pkg.sv
// Shared constants, FSM encoding and helpers for the Difftest commit tracker.
package difftest_commit_tracker_pkg;

  localparam logic [63:0] PC_START_DEF    = 64'h0000_0000_8000_0000;
  localparam logic [6:0]  TRAP_OPCODE_DEF = 7'h6b;
  localparam int          MAX_LANES       = 4;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } cmt_state_e;

  // Architectural register write as reported to Difftest (wdest widened to 8 bits).
  typedef struct packed {
    logic       wen;
    logic [7:0] wdest;
  } reg_bus_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/difftest_commit_tracker_if.sv
// Retire-side inputs and Difftest-side outputs of the commit tracker.
interface difftest_commit_tracker_if #(
  parameter int W    = 2,
  parameter int XLEN = 64
);
  logic [W-1:0]            in_valid;
  logic [W-1:0][XLEN-1:0]  in_pc;
  logic [W-1:0][31:0]      in_inst;
  logic [W-1:0]            in_wen;
  logic [W-1:0][4:0]       in_wdest;
  logic [W-1:0][XLEN-1:0]  in_wdata;
  logic [XLEN-1:0]         in_a0;

  logic [W-1:0]            cmt_valid;
  logic [W-1:0][XLEN-1:0]  cmt_pc;
  logic [W-1:0][31:0]      cmt_inst;
  logic [W-1:0]            cmt_wen;
  logic [W-1:0][7:0]       cmt_wdest;
  logic [W-1:0][XLEN-1:0]  cmt_wdata;
  logic                    trap_valid;
  logic [7:0]              trap_code;
  logic [XLEN-1:0]         trap_pc;
  logic [63:0]             cycle_cnt;
  logic [63:0]             instr_cnt;
  logic                    order_err;

  modport master (
    output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_a0,
    input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata,
    input  trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, order_err
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_a0,
    output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata,
    output trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, order_err
  );

endinterface

// File: rtl/difftest_commit_tracker_commit_lane_reg.sv
// One commit lane: filters reset bubbles, flags the trap opcode and registers the commit.
module commit_lane_reg
  import difftest_commit_tracker_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] PC_START    = PC_START_DEF[XLEN-1:0],
  parameter logic [6:0]      TRAP_OPCODE = TRAP_OPCODE_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            wen,
  input  logic [4:0]      wdest,
  input  logic [XLEN-1:0] wdata,
  output logic            is_trap,
  output logic            accept,
  output logic            cmt_valid,
  output logic [XLEN-1:0] cmt_pc,
  output logic [31:0]     cmt_inst,
  output logic            cmt_wen,
  output logic [7:0]      cmt_wdest,
  output logic [XLEN-1:0] cmt_wdata
);

  logic live_s;

  assign live_s  = valid && !((pc == PC_START) && (inst == 32'd0));
  assign is_trap = live_s && (inst[6:0] == TRAP_OPCODE);
  assign accept  = enable && live_s;

  // Payload loads only on accept; an x0 write is never reported as a GPR write.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmt_valid <= 1'b0;
      cmt_pc    <= '0;
      cmt_inst  <= 32'd0;
      cmt_wen   <= 1'b0;
      cmt_wdest <= 8'd0;
      cmt_wdata <= '0;
    end else begin
      cmt_valid <= accept;
      cmt_wen   <= accept && wen && (wdest != 5'd0);
      if (accept) begin
        cmt_pc    <= pc;
        cmt_inst  <= inst;
        cmt_wdest <= {3'b000, wdest};
        cmt_wdata <= wdata;
      end else begin
        cmt_pc    <= cmt_pc;
        cmt_inst  <= cmt_inst;
        cmt_wdest <= cmt_wdest;
        cmt_wdata <= cmt_wdata;
      end
    end
  end

endmodule

// File: rtl/difftest_commit_tracker.sv
// Multi-lane Difftest commit tracker: lane filtering, trap/halt FSM and counters.
// Optional idle watchdog enabled by defining CMT_WATCHDOG_EN.
module difftest_commit_tracker
  import difftest_commit_tracker_pkg::*;
#(
  parameter int          COMMIT_WIDTH = 2,
  parameter int          XLEN         = 64,
  parameter logic [63:0] PC_START     = PC_START_DEF,
  parameter logic [6:0]  TRAP_OPCODE  = TRAP_OPCODE_DEF,
  parameter int          WDOG_CYCLES  = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  difftest_commit_tracker_if.slave   io
);

  if (COMMIT_WIDTH < 1 || COMMIT_WIDTH > MAX_LANES || WDOG_CYCLES < 1 || XLEN < 8) begin : g_param_check
    $error("difftest_commit_tracker: unsupported parameter value");
  end

  cmt_state_e                         state_r, state_n;
  logic                               run_s;
  logic [COMMIT_WIDTH-1:0]            enable_s, is_trap_s, accept_s;
  logic                               seen_trap_s, trap_hit_s, order_err_s, halt_s;
  logic [XLEN-1:0]                    trap_pc_s, halt_pc_s, wdog_pc_s;
  logic [7:0]                         halt_code_s;
  logic [MAX_LANES-1:0]               acc4_s;
  logic [2:0]                         acc_cnt_s;
  logic                               wdog_hit_s;
  logic [COMMIT_WIDTH-1:0]            cmt_valid_s, cmt_wen_s;
  logic [COMMIT_WIDTH-1:0][XLEN-1:0]  cmt_pc_s, cmt_wdata_s;
  logic [COMMIT_WIDTH-1:0][31:0]      cmt_inst_s;
  logic [COMMIT_WIDTH-1:0][7:0]       cmt_wdest_s;
  logic [63:0]                        cycle_cnt_r, instr_cnt_r;
  logic                               trap_valid_r, order_err_r;
  logic [7:0]                         trap_code_r;
  logic [XLEN-1:0]                    trap_pc_r;
  logic                               unused_a0_s;

  assign run_s       = (state_r == ST_RUN);
  assign unused_a0_s = ^io.in_a0[XLEN-1:8];

  for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_lane
    commit_lane_reg #(
      .XLEN        (XLEN),
      .PC_START    (PC_START[XLEN-1:0]),
      .TRAP_OPCODE (TRAP_OPCODE)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable_s[g]),
      .valid     (io.in_valid[g]),
      .pc        (io.in_pc[g]),
      .inst      (io.in_inst[g]),
      .wen       (io.in_wen[g]),
      .wdest     (io.in_wdest[g]),
      .wdata     (io.in_wdata[g]),
      .is_trap   (is_trap_s[g]),
      .accept    (accept_s[g]),
      .cmt_valid (cmt_valid_s[g]),
      .cmt_pc    (cmt_pc_s[g]),
      .cmt_inst  (cmt_inst_s[g]),
      .cmt_wen   (cmt_wen_s[g]),
      .cmt_wdest (cmt_wdest_s[g]),
      .cmt_wdata (cmt_wdata_s[g])
    );
  end

  // Oldest trapping lane wins; it still commits while every younger lane is dropped.
  always_comb begin
    seen_trap_s = 1'b0;
    enable_s    = '0;
    trap_pc_s   = '0;
    order_err_s = 1'b0;
    acc4_s      = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      enable_s[i] = run_s && !seen_trap_s;
      trap_pc_s   = (!seen_trap_s && is_trap_s[i]) ? io.in_pc[i] : trap_pc_s;
      seen_trap_s = seen_trap_s || is_trap_s[i];
    end
    for (int i = 1; i < COMMIT_WIDTH; i++) begin
      order_err_s = order_err_s || (io.in_valid[i] && !io.in_valid[i-1]);
    end
    trap_hit_s = run_s && seen_trap_s;
    acc4_s[COMMIT_WIDTH-1:0] = accept_s;
    acc_cnt_s = popcount4(acc4_s);
  end

`ifdef CMT_WATCHDOG_EN
  logic [31:0]     idle_cnt_r;
  logic [XLEN-1:0] last_pc_r, youngest_pc_s;

  // Youngest accepted lane this cycle becomes the last committed pc.
  always_comb begin
    youngest_pc_s = last_pc_r;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      youngest_pc_s = accept_s[i] ? io.in_pc[i] : youngest_pc_s;
    end
  end

  assign wdog_hit_s = run_s && (accept_s == '0) && (idle_cnt_r == 32'(WDOG_CYCLES - 1));
  assign wdog_pc_s  = last_pc_r;

  // Idle counter runs only in RUN and restarts on any accepted lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt_r <= 32'd0;
      last_pc_r  <= '0;
    end else if (run_s && (accept_s != '0)) begin
      idle_cnt_r <= 32'd0;
      last_pc_r  <= youngest_pc_s;
    end else if (run_s) begin
      idle_cnt_r <= idle_cnt_r + 32'd1;
    end
  end
`else
  assign wdog_hit_s = 1'b0;
  assign wdog_pc_s  = '0;
`endif

  // Halt cause select: a real trap reports a0, the watchdog reports 8'hFF.
  always_comb begin
    halt_s = trap_hit_s || wdog_hit_s;
    if (trap_hit_s) begin
      halt_code_s = io.in_a0[7:0];
      halt_pc_s   = trap_pc_s;
    end else begin
      halt_code_s = 8'hFF;
      halt_pc_s   = wdog_pc_s;
    end
  end

  // FSM next state: HALT is absorbing until reset.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_RUN:  state_n = halt_s ? ST_HALT : ST_RUN;
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= ST_RUN;
    else       state_r <= state_n;
  end

  // Counters and sticky status; all frozen once HALT is reached.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_r  <= 64'd0;
      instr_cnt_r  <= 64'd0;
      trap_valid_r <= 1'b0;
      trap_code_r  <= 8'd0;
      trap_pc_r    <= '0;
      order_err_r  <= 1'b0;
    end else if (run_s) begin
      cycle_cnt_r <= cycle_cnt_r + 64'd1;
      instr_cnt_r <= instr_cnt_r + {61'd0, acc_cnt_s};
      order_err_r <= order_err_r || order_err_s;
      if (halt_s) begin
        trap_valid_r <= 1'b1;
        trap_code_r  <= halt_code_s;
        trap_pc_r    <= halt_pc_s;
      end
    end
  end

  assign io.cmt_valid  = cmt_valid_s;
  assign io.cmt_pc     = cmt_pc_s;
  assign io.cmt_inst   = cmt_inst_s;
  assign io.cmt_wen    = cmt_wen_s;
  assign io.cmt_wdest  = cmt_wdest_s;
  assign io.cmt_wdata  = cmt_wdata_s;
  assign io.trap_valid = trap_valid_r;
  assign io.trap_code  = trap_code_r;
  assign io.trap_pc    = trap_pc_r;
  assign io.cycle_cnt  = cycle_cnt_r;
  assign io.instr_cnt  = instr_cnt_r;
  assign io.order_err  = order_err_r;

endmodule

// File: tb/tb_difftest_commit_tracker.sv
// Scoreboard bench for difftest_commit_tracker (2 lanes, 64-bit); CMT_WATCHDOG_EN selects the watchdog scenario.
module tb_difftest_commit_tracker;
  import difftest_commit_tracker_pkg::*;

  localparam int          W    = 2;
  localparam int          XLEN = 64;
  localparam logic [63:0] PCS  = 64'h0000_0000_8000_0000;
`ifdef CMT_WATCHDOG_EN
  localparam int          WDOG = 8;
`else
  localparam int          WDOG = 4096;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  difftest_commit_tracker_if #(.W(W), .XLEN(XLEN)) bus();

  difftest_commit_tracker #(
    .COMMIT_WIDTH (W),
    .XLEN         (XLEN),
    .PC_START     (PCS),
    .TRAP_OPCODE  (7'h6b),
    .WDOG_CYCLES  (WDOG)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  typedef struct packed {
    logic [1:0]  valid;
    logic [1:0]  wen;
    logic [63:0] instr;
    logic [63:0] cyc;
    logic        trap;
    logic [7:0]  code;
    logic        oerr;
  } exp_t;

  exp_t        sb[$];
  exp_t        e, o;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_instr, exp_cyc;
  logic        exp_oerr;

  function automatic exp_t observe();
    return {bus.cmt_valid, bus.cmt_wen, bus.instr_cnt, bus.cycle_cnt,
            bus.trap_valid, bus.trap_code, bus.order_err};
  endfunction

  // Drive one cycle of retirements (called just after an edge), then sample #1 after the next edge.
  task automatic step(input logic [1:0] v, input logic [63:0] p0, input logic [31:0] i0,
                      input logic [63:0] p1, input logic [31:0] i1, input logic [1:0] we,
                      input logic [4:0] d0, input logic [4:0] d1, input logic [63:0] a0);
    bus.in_valid    = v;
    bus.in_pc[0]    = p0;
    bus.in_pc[1]    = p1;
    bus.in_inst[0]  = i0;
    bus.in_inst[1]  = i1;
    bus.in_wen      = we;
    bus.in_wdest[0] = d0;
    bus.in_wdest[1] = d1;
    bus.in_wdata[0] = p0 ^ 64'h5a5a;
    bus.in_wdata[1] = p1 ^ 64'ha5a5;
    bus.in_a0       = a0;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    bus.in_valid   = 2'b11;
    bus.in_pc[0]   = PCS + 64'h40;
    bus.in_inst[0] = 32'h0000006b;
    bus.in_wen     = 2'b11;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic release_reset();
    reset     = 1'b0;
    exp_instr = 64'd0;
    exp_cyc   = 64'd0;
    exp_oerr  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++; if (observe() !== '0) begin errors++; $display("FAIL reset_status got=%h exp=0", observe()); end
    checks++; if (bus.trap_pc !== 64'd0) begin errors++; $display("FAIL reset_trap_pc got=%h exp=0", bus.trap_pc); end
    checks++; if ({bus.cmt_pc, bus.cmt_inst, bus.cmt_wdest, bus.cmt_wdata} !== '0) begin
      errors++; $display("FAIL reset_payload got=%h exp=0", {bus.cmt_pc, bus.cmt_inst, bus.cmt_wdest, bus.cmt_wdata});
    end
    release_reset();
  endtask

  task automatic test_basic();
    exp_instr += 64'd2; exp_cyc += 64'd1;
    sb.push_back({2'b11, 2'b00, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b11, PCS, 32'h00000013, PCS + 64'd4, 32'h00100093, 2'b00, 5'd0, 5'd0, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL basic_commit got=%h exp=%h", o, e); end
    checks++; if (bus.cmt_pc[1] !== PCS + 64'd4) begin errors++; $display("FAIL basic_pc1 got=%h exp=%h", bus.cmt_pc[1], PCS + 64'd4); end
    checks++; if (bus.cmt_inst[1] !== 32'h00100093) begin errors++; $display("FAIL basic_inst1 got=%h exp=00100093", bus.cmt_inst[1]); end
  endtask

  task automatic test_bubble();
    exp_cyc += 64'd1;
    sb.push_back({2'b00, 2'b00, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b01, PCS, 32'd0, 64'd0, 32'd0, 2'b00, 5'd0, 5'd0, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL bubble_only got=%h exp=%h", o, e); end
    exp_instr += 64'd1; exp_cyc += 64'd1;
    sb.push_back({2'b10, 2'b00, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b11, PCS, 32'd0, PCS + 64'h8, 32'h00000013, 2'b00, 5'd0, 5'd0, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL bubble_lane0 got=%h exp=%h", o, e); end
  endtask

  task automatic test_wen();
    exp_instr += 64'd2; exp_cyc += 64'd1;
    sb.push_back({2'b11, 2'b10, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b11, PCS + 64'h10, 32'h00000013, PCS + 64'h14, 32'h00500293, 2'b11, 5'd0, 5'd5, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL wen_x0 got=%h exp=%h", o, e); end
    checks++; if ({bus.cmt_wdest[1], bus.cmt_wdest[0]} !== {8'd5, 8'd0}) begin
      errors++; $display("FAIL wen_wdest got=%h exp=0500", {bus.cmt_wdest[1], bus.cmt_wdest[0]});
    end
    exp_instr += 64'd2; exp_cyc += 64'd1;
    sb.push_back({2'b11, 2'b01, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b11, PCS + 64'h18, 32'h00300193, PCS + 64'h1c, 32'h00000013, 2'b01, 5'd3, 5'd7, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL wen_lane0 got=%h exp=%h", o, e); end
  endtask

  task automatic test_order();
    exp_instr += 64'd1; exp_cyc += 64'd1; exp_oerr = 1'b1;
    sb.push_back({2'b10, 2'b00, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b10, 64'd0, 32'd0, PCS + 64'h20, 32'h00000013, 2'b00, 5'd0, 5'd0, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL order_set got=%h exp=%h", o, e); end
    checks++; if (bus.cmt_pc[1] !== PCS + 64'h20) begin errors++; $display("FAIL order_pc1 got=%h exp=%h", bus.cmt_pc[1], PCS + 64'h20); end
    exp_cyc += 64'd1;
    sb.push_back({2'b00, 2'b00, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b00, 5'd0, 5'd0, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL order_sticky got=%h exp=%h", o, e); end
  endtask

`ifdef CMT_WATCHDOG_EN
  task automatic test_watchdog();
    apply_reset(1);
    release_reset();
    exp_instr += 64'd1; exp_cyc += 64'd1;
    sb.push_back({2'b01, 2'b00, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b01, PCS + 64'h300, 32'h00000013, 64'd0, 32'd0, 2'b00, 5'd0, 5'd0, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL wdog_commit got=%h exp=%h", o, e); end
    for (int k = 1; k <= WDOG + 1; k++) begin
      if (k <= WDOG) exp_cyc += 64'd1;
      sb.push_back({2'b00, 2'b00, exp_instr, exp_cyc, (k >= WDOG), (k >= WDOG) ? 8'hFF : 8'h00, exp_oerr});
      step(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b00, 5'd0, 5'd0, 64'd0);
      e = sb.pop_front(); o = observe();
      checks++; if (o !== e) begin errors++; $display("FAIL wdog_idle%0d got=%h exp=%h", k, o, e); end
    end
    checks++; if (bus.trap_pc !== PCS + 64'h300) begin errors++; $display("FAIL wdog_pc got=%h exp=%h", bus.trap_pc, PCS + 64'h300); end
    apply_reset(1);
    checks++; if (observe() !== '0) begin errors++; $display("FAIL wdog_reset got=%h exp=0", observe()); end
    checks++; if (bus.trap_pc !== 64'd0) begin errors++; $display("FAIL wdog_reset_pc got=%h exp=0", bus.trap_pc); end
    release_reset();
  endtask
`else
  task automatic test_idle();
    for (int k = 0; k < 20; k++) begin
      exp_cyc += 64'd1;
      sb.push_back({2'b00, 2'b00, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
      step(2'b00, 64'd0, 32'd0, 64'd0, 32'd0, 2'b00, 5'd0, 5'd0, 64'd0);
      e = sb.pop_front(); o = observe();
      checks++; if (o !== e) begin errors++; $display("FAIL idle%0d got=%h exp=%h", k, o, e); end
    end
  endtask
`endif

  task automatic test_trap();
    exp_instr += 64'd1; exp_cyc += 64'd1;
    sb.push_back({2'b01, 2'b00, exp_instr, exp_cyc, 1'b1, 8'h01, exp_oerr});
    step(2'b11, PCS + 64'h200, 32'h0000006b, PCS + 64'h204, 32'h00000013, 2'b00, 5'd0, 5'd0, 64'h1);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL trap_hit got=%h exp=%h", o, e); end
    checks++; if (bus.trap_pc !== PCS + 64'h200) begin errors++; $display("FAIL trap_pc got=%h exp=%h", bus.trap_pc, PCS + 64'h200); end
    for (int k = 0; k < 3; k++) begin
      sb.push_back({2'b00, 2'b00, exp_instr, exp_cyc, 1'b1, 8'h01, exp_oerr});
      step(2'b11, PCS + 64'h208, (k == 1) ? 32'h0000006b : 32'h00000013, PCS + 64'h20c, 32'h00000013, 2'b11, 5'd1, 5'd2, 64'h55);
      e = sb.pop_front(); o = observe();
      checks++; if (o !== e) begin errors++; $display("FAIL trap_frozen%0d got=%h exp=%h", k, o, e); end
    end
  endtask

  task automatic test_halt_reset();
    apply_reset(1);
    checks++; if (observe() !== '0) begin errors++; $display("FAIL halt_reset got=%h exp=0", observe()); end
    checks++; if (bus.trap_pc !== 64'd0) begin errors++; $display("FAIL halt_reset_pc got=%h exp=0", bus.trap_pc); end
    release_reset();
    exp_instr += 64'd2; exp_cyc += 64'd1;
    sb.push_back({2'b11, 2'b00, exp_instr, exp_cyc, 1'b0, 8'h00, exp_oerr});
    step(2'b11, PCS + 64'h400, 32'h00000013, PCS + 64'h404, 32'h00000013, 2'b00, 5'd0, 5'd0, 64'd0);
    e = sb.pop_front(); o = observe();
    checks++; if (o !== e) begin errors++; $display("FAIL after_reset got=%h exp=%h", o, e); end
  endtask

  initial begin
    bus.in_valid = '0;
    bus.in_pc    = '0;
    bus.in_inst  = '0;
    bus.in_wen   = '0;
    bus.in_wdest = '0;
    bus.in_wdata = '0;
    bus.in_a0    = '0;
    exp_instr    = 64'd0;
    exp_cyc      = 64'd0;
    exp_oerr     = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_bubble();
    test_wen();
    test_order();
`ifdef CMT_WATCHDOG_EN
    test_watchdog();
`else
    test_idle();
`endif
    test_trap();
    test_halt_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
